// File: rtl/clks_alot_tx_pkg.sv
// Shared constants, bus lane bundle and tx state encoding
// for the clks_alot serial transmitter.
package clks_alot_p;

    localparam int SYS_CLOCK_MULTIPLE            = 64;
    localparam int TARGET_SHORT_LENGTH           = 384;
    localparam int TARGET_LONG_LENGTH            = 3840;
    localparam int NEGEDGES_BETWEEN_SHORT_PAUSES = 32;
    localparam int CYCLES_PER_BIT                = 2;
    localparam int TRANSMITTED_BITS              = 16;

    localparam int TX_FRAME_WIDTH    = 2 * TRANSMITTED_BITS;
    localparam int TX_PAUSE_BITWIDTH = $clog2(TARGET_LONG_LENGTH);
    localparam int TX_PHASE_BITWIDTH = $clog2(SYS_CLOCK_MULTIPLE);
    localparam int TX_IO_BITWIDTH    = $clog2(NEGEDGES_BETWEEN_SHORT_PAUSES);

    typedef struct packed {
        logic clk;
        logic addr;
        logic data_high;
        logic data_low;
    } interface_s;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_RUN,
        TX_SHORT_PAUSE,
        TX_LONG_PAUSE
    } tx_state_e;

endpackage

// File: rtl/clks_alot_tx_clkgen.sv
// Phase counter for one io cycle; produces the io clock and
// strobes that fire one sys cycle ahead of each io clock edge.
module clks_alot_tx_clkgen
    import clks_alot_p::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic clk_o,
    output logic fall_o,
    output logic rise_o
);

    localparam logic [TX_PHASE_BITWIDTH-1:0] PH_HALF =
        TX_PHASE_BITWIDTH'(SYS_CLOCK_MULTIPLE / 2);
    localparam logic [TX_PHASE_BITWIDTH-1:0] PH_LAST =
        TX_PHASE_BITWIDTH'(SYS_CLOCK_MULTIPLE - 1);

    logic [TX_PHASE_BITWIDTH-1:0] phase_q;
    logic [TX_PHASE_BITWIDTH-1:0] phase_d;

    always_comb begin
        phase_d = '0;
        if (run_i) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign clk_o  = run_i && (phase_q < PH_HALF);
    // Strobes lead the edge so registered lanes change on it.
    assign fall_o = run_i && (phase_q == PH_HALF - 1'b1);
    assign rise_o = run_i && (phase_q == PH_LAST);

endmodule

// File: rtl/clks_alot_tx.sv
// Frame transmitter: FSM, frame shifters and inter-frame pauses
// driving the clk/addr/data_high/data_low lanes.
module clks_alot_tx
    import clks_alot_p::*;
(
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      enable,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic                      tx_addr,
    input  logic [TX_FRAME_WIDTH-1:0] tx_data,
    input  logic                      long_pause_req,
    output interface_s                bus,
    output logic                      frame_done,
    output logic                      busy
);

    localparam logic [TX_IO_BITWIDTH-1:0] IO_LAST =
        TX_IO_BITWIDTH'(NEGEDGES_BETWEEN_SHORT_PAUSES - 1);
    localparam logic [TX_PAUSE_BITWIDTH-1:0] SHORT_LAST =
        TX_PAUSE_BITWIDTH'(TARGET_SHORT_LENGTH - 1);
    localparam logic [TX_PAUSE_BITWIDTH-1:0] LONG_LAST =
        TX_PAUSE_BITWIDTH'(TARGET_LONG_LENGTH - 1);
    localparam int HB = TRANSMITTED_BITS;

    tx_state_e                    state_q, state_d;
    logic [TX_IO_BITWIDTH-1:0]    io_q, io_d;
    logic [TX_PAUSE_BITWIDTH-1:0] pause_q, pause_d;
    logic                         pend_q, pend_d;
    logic                         addr_q, addr_d;
    logic [HB-1:0]                dh_q, dh_d;
    logic [HB-1:0]                dl_q, dl_d;
    logic                         done_q, done_d;

    logic run;
    logic io_clk;
    logic fall_next;
    logic wrap;
    logic bit_last;
    logic pause_end;
    logic accept;

    assign run = (state_q == TX_RUN);

    clks_alot_tx_clkgen u_clkgen (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .run_i  (run),
        .clk_o  (io_clk),
        .fall_o (fall_next),
        .rise_o (wrap)
    );

    assign bit_last = ((int'(io_q) % CYCLES_PER_BIT) == CYCLES_PER_BIT - 1);

    assign pause_end =
        ((state_q == TX_SHORT_PAUSE) && (pause_q == SHORT_LAST)) ||
        ((state_q == TX_LONG_PAUSE)  && (pause_q == LONG_LAST));

    assign tx_ready = enable && !sys_rst &&
                      ((state_q == TX_IDLE) || pause_end);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        io_d    = io_q;
        pause_d = '0;
        pend_d  = pend_q | long_pause_req;
        addr_d  = addr_q;
        dh_d    = dh_q;
        dl_d    = dl_q;
        done_d  = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    state_d = TX_RUN;
                end
            end
            TX_RUN: begin
                if (fall_next && bit_last) begin
                    dh_d = {dh_q[HB-2:0], 1'b0};
                    dl_d = {dl_q[HB-2:0], 1'b0};
                end
                if (wrap) begin
                    if (io_q == IO_LAST) begin
                        done_d = 1'b1;
                        io_d   = '0;
                        if (pend_q || long_pause_req) begin
                            state_d = TX_LONG_PAUSE;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = TX_SHORT_PAUSE;
                        end
                    end else begin
                        io_d = io_q + 1'b1;
                    end
                end
            end
            TX_SHORT_PAUSE, TX_LONG_PAUSE: begin
                pause_d = pause_q + 1'b1;
                if (pause_end) begin
                    pause_d = '0;
                    state_d = accept ? TX_RUN : TX_IDLE;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        if (accept) begin
            addr_d = tx_addr;
            dh_d   = tx_data[TX_FRAME_WIDTH-1:HB];
            dl_d   = tx_data[HB-1:0];
            io_d   = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= TX_IDLE;
            io_q    <= '0;
            pause_q <= '0;
            pend_q  <= 1'b0;
            addr_q  <= 1'b0;
            dh_q    <= '0;
            dl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            io_q    <= io_d;
            pause_q <= pause_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            dh_q    <= dh_d;
            dl_q    <= dl_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        bus           = '0;
        bus.clk       = io_clk;
        bus.addr      = addr_q;
        bus.data_high = run && dh_q[HB-1];
        bus.data_low  = run && dl_q[HB-1];
    end

    assign frame_done = done_q;
    assign busy       = (state_q != TX_IDLE);

endmodule

// File: tb/tb_clks_alot_tx.sv
// Directed bench for clks_alot_tx: frame shape, pauses,
// back-to-back, long requests, enable drop and mid-frame reset.
module tb_clks_alot_tx;
    import clks_alot_p::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        enable;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_addr;
    logic [31:0] tx_data;
    logic        long_pause_req;
    interface_s  bus;
    logic        frame_done;
    logic        busy;

    int n_asrt = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    clks_alot_tx dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .enable         (enable),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_addr        (tx_addr),
        .tx_data        (tx_data),
        .long_pause_req (long_pause_req),
        .bus            (bus),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] d, input logic a);
        tx_data  = d;
        tx_addr  = a;
        tx_valid = 1'b1;
        #1;
        check("ready_idle", 32'(tx_ready), 32'd1);
        step();
    endtask

    // Starts in the clk-rise cycle; ends in the frame_done cycle.
    task automatic run_frame(input logic [31:0] d, input logic a,
                             input int req_io, input int en_off_io);
        int   bad_clk = 0;
        int   bad_dat = 0;
        int   bad_ctl = 0;
        int   rises = 0;
        int   io;
        int   ph;
        int   k;
        logic exp_clk;
        logic prev = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            io = i / 64;
            ph = i % 64;
            long_pause_req = (req_io >= 0) && (i == req_io * 64);
            if (en_off_io >= 0 && i == en_off_io * 64) enable = 1'b0;
            #1;
            exp_clk = (ph < 32);
            if (bus.clk !== exp_clk) bad_clk++;
            if (bus.clk && !prev) rises++;
            prev = bus.clk;
            k = io / 2 + (((io % 2) == 1 && ph >= 32) ? 1 : 0);
            if (k <= 15) begin
                if (bus.data_high !== d[31-k] ||
                    bus.data_low !== d[15-k]) bad_dat++;
            end
            if (bus.addr !== a || busy !== 1'b1 ||
                tx_ready !== 1'b0 || frame_done !== 1'b0) bad_ctl++;
            step();
        end
        long_pause_req = 1'b0;
        #1;
        check("clk_shape", bad_clk, 0);
        check("clk_rises", rises, 32);
        check("data_bits", bad_dat, 0);
        check("run_ctl", bad_ctl, 0);
        check("frame_done", 32'(frame_done), 32'd1);
    endtask

    // Counts cycles from frame_done until the next rise or IDLE.
    task automatic pause_expect(input logic a, input int exp_len,
                                input int exp_rdy, input logic to_idle);
        int len = 0;
        int rdy_cnt = 0;
        int rdy_at = -1;
        int bad = 0;
        while (busy && !bus.clk && len < 5000) begin
            if (tx_ready) begin
                rdy_cnt++;
                rdy_at = len;
            end
            if (bus.data_high || bus.data_low || bus.addr !== a ||
                (len > 0 && frame_done)) bad++;
            @(posedge sys_clk);
            #2;
            len++;
        end
        check("pause_lanes", bad, 0);
        check("pause_len", len, exp_len);
        check("pause_ready_cnt", rdy_cnt, exp_rdy);
        if (exp_rdy > 0) check("pause_ready_at", rdy_at, exp_len - 1);
        if (to_idle) begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_bus", 32'(bus), {28'd0, 1'b0, a, 2'b00});
        end else begin
            check("b2b_rise", 32'(bus.clk), 32'd1);
        end
    endtask

    initial begin
        int bad;
        sys_rst        = 1'b1;
        enable         = 1'b1;
        tx_valid       = 1'b0;
        tx_addr        = 1'b0;
        tx_data        = '0;
        long_pause_req = 1'b0;
        repeat (3) step();
        check("rst_bus", 32'(bus), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        sys_rst = 1'b0;
        step();
        check("idle_ready", 32'(tx_ready), 32'd1);

        // single frame
        start_frame(32'hA5A5_3C3C, 1'b1);
        tx_valid = 1'b0;
        check("first_bits", 32'(bus), {28'd0, 4'b1110});
        run_frame(32'hA5A5_3C3C, 1'b1, -1, -1);
        pause_expect(1'b1, 384, 1, 1'b1);

        // three frames back to back
        start_frame(32'h1234_F00F, 1'b0);
        run_frame(32'h1234_F00F, 1'b0, -1, -1);
        pause_expect(1'b0, 384, 1, 1'b0);
        run_frame(32'h1234_F00F, 1'b0, -1, -1);
        pause_expect(1'b0, 384, 1, 1'b0);
        tx_valid = 1'b0;
        run_frame(32'h1234_F00F, 1'b0, -1, -1);
        pause_expect(1'b0, 384, 1, 1'b1);

        // long request mid-frame
        start_frame(32'hDEAD_BEEF, 1'b1);
        run_frame(32'hDEAD_BEEF, 1'b1, 10, -1);
        pause_expect(1'b1, 3840, 1, 1'b0);
        tx_valid = 1'b0;
        run_frame(32'hDEAD_BEEF, 1'b1, -1, -1);
        pause_expect(1'b1, 384, 1, 1'b1);

        // enable dropped mid-frame
        start_frame(32'h0F0F_8001, 1'b0);
        tx_valid = 1'b0;
        run_frame(32'h0F0F_8001, 1'b0, -1, 5);
        pause_expect(1'b0, 384, 0, 1'b1);
        tx_valid = 1'b1;
        repeat (3) step();
        check("disabled_ready", 32'(tx_ready), 32'd0);
        check("disabled_busy", 32'(busy), 32'd0);
        tx_valid = 1'b0;
        enable   = 1'b1;
        #1;
        check("reenabled_ready", 32'(tx_ready), 32'd1);

        // reset at phase 10 of io cycle 7, with a long request pending
        start_frame(32'h5555_AAAA, 1'b1);
        tx_valid = 1'b0;
        for (int i = 0; i < 7 * 64 + 10; i++) begin
            long_pause_req = (i == 192);
            step();
        end
        long_pause_req = 1'b0;
        sys_rst = 1'b1;
        step();
        check("midrst_bus", 32'(bus), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        sys_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 2200; i++) begin
            if (frame_done || busy || bus.clk) bad++;
            step();
        end
        check("post_rst_quiet", bad, 0);
        start_frame(32'hC3C3_0FF0, 1'b0);
        tx_valid = 1'b0;
        run_frame(32'hC3C3_0FF0, 1'b0, -1, -1);
        pause_expect(1'b0, 384, 1, 1'b1);

        // long request while idle
        long_pause_req = 1'b1;
        step();
        long_pause_req = 1'b0;
        repeat (4) step();
        start_frame(32'h8000_0001, 1'b1);
        tx_valid = 1'b0;
        run_frame(32'h8000_0001, 1'b1, -1, -1);
        pause_expect(1'b1, 3840, 1, 1'b1);

        // long request in the handshake cycle
        long_pause_req = 1'b1;
        start_frame(32'h0001_8000, 1'b0);
        long_pause_req = 1'b0;
        tx_valid = 1'b0;
        run_frame(32'h0001_8000, 1'b0, -1, -1);
        pause_expect(1'b0, 3840, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
